// File: rtl/rr_stream_mux.sv
// Registered N-to-1 stream multiplexer with round-robin or fixed-priority arbitration.
// One output register stage; streams one word per cycle when the consumer keeps up.
module rr_stream_mux #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        arb_mode,
    input  logic [NUM_IN-1:0]           in_valid,
    input  logic [NUM_IN*WIDTH-1:0]     in_data,
    output logic [NUM_IN-1:0]           in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic [$clog2(NUM_IN)-1:0]   out_sel,
    input  logic                        out_ready
);

    localparam int SEL_W = $clog2(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

    // Handshake: a word moves on any channel only in a cycle where its valid and
    // ready are both high at the rising clk edge; producers hold valid/data until
    // then, and ready never depends on data.

    logic [SEL_W-1:0]  rr_ptr;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;
    logic              can_load;
    logic              load;

    assign can_load = !out_valid || out_ready;

    // Round-robin searches upward from rr_ptr with wrap; fixed priority from index 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = 0; off < NUM_IN; off++) begin
            int idx;
            idx = arb_mode ? off : ((int'(rr_ptr) + off) % NUM_IN);
            if (!grant_any && in_valid[idx]) begin
                grant_any  = 1'b1;
                grant_idx  = SEL_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    // rst_n gates ready so nothing appears accepted while the block is held in reset.
    assign in_ready = (can_load && rst_n) ? grant : '0;
    assign load     = grant_any && can_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
                out_sel   <= grant_idx;
                if (!arb_mode) begin
                    rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: reset, round-robin, fixed priority,
// backpressure, sparse wrap, drain and asynchronous reset mid-stream.
module tb_rr_stream_mux;

    localparam int WIDTH  = 16;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = $clog2(NUM_IN);

    logic                     clk;
    logic                     rst_n;
    logic                     arb_mode;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*WIDTH-1:0]  in_data;
    logic [NUM_IN-1:0]        in_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [SEL_W-1:0]         out_sel;
    logic                     out_ready;

    int total  = 0;
    int passed = 0;

    rr_stream_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk(clk), .rst_n(rst_n), .arb_mode(arb_mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full output-register snapshot against expectations.
    task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                             input logic [1:0] s);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".sel"},   32'(out_sel),   32'(s));
    endtask

    initial begin
        in_data   = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
        rst_n     = 1'b0;
        arb_mode  = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;

        // Reset with all channels valid
        #3;
        check_out("rst", 1'b0, 16'h0000, 2'd0);
        check("rst.in_ready", 32'(in_ready), 32'h0);
        tick();
        tick();
        check_out("rst_edges", 1'b0, 16'h0000, 2'd0);
        check("rst_edges.in_ready", 32'(in_ready), 32'h0);

        // Release: pointer at 0, channel 0 first
        rst_n = 1'b1;
        #1;
        check("rel.in_ready", 32'(in_ready), 32'b0001);
        tick();
        check_out("rr0", 1'b1, 16'h1234, 2'd0);
        check("rr0.in_ready", 32'(in_ready), 32'b0010);
        tick();
        check_out("rr1", 1'b1, 16'h5678, 2'd1);
        tick();
        check_out("rr2", 1'b1, 16'h9ABC, 2'd2);
        tick();
        check_out("rr3", 1'b1, 16'hDEF0, 2'd3);
        check("rr3.in_ready", 32'(in_ready), 32'b0001);
        tick();
        check_out("rr4", 1'b1, 16'h1234, 2'd0);

        // Fixed priority: channel 0 always wins, pointer stays at 1
        arb_mode = 1'b1;
        #1;
        check("fp.in_ready", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("fp", 1'b1, 16'h1234, 2'd0);
            check("fp.in_ready", 32'(in_ready), 32'b0001);
        end

        // Back to round-robin: pointer resumes at 1
        arb_mode = 1'b0;
        #1;
        check("bp.pre_ready", 32'(in_ready), 32'b0010);
        tick();
        check_out("bp.load", 1'b1, 16'h5678, 2'd1);
        out_ready = 1'b0;
        #1;
        check("bp.in_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("bp.stall", 1'b1, 16'h5678, 2'd1);
            check("bp.stall_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.resume_ready", 32'(in_ready), 32'b0100);
        tick();
        check_out("bp.nobubble", 1'b1, 16'h9ABC, 2'd2);

        // Sparse: pointer at 3, only channel 3 then only channel 0
        in_valid = 4'b1000;
        #1;
        check("sp.ready3", 32'(in_ready), 32'b1000);
        tick();
        check_out("sp.ch3", 1'b1, 16'hDEF0, 2'd3);
        in_valid = 4'b0001;
        #1;
        check("sp.ready0", 32'(in_ready), 32'b0001);
        tick();
        check_out("sp.ch0", 1'b1, 16'h1234, 2'd0);
        // Pointer now 1: channel 1 beats channel 0
        in_valid = 4'b0011;
        #1;
        check("sp.ptr1", 32'(in_ready), 32'b0010);
        tick();
        check_out("sp.ch1", 1'b1, 16'h5678, 2'd1);

        // Drain with no valid inputs: data and sel hold
        in_valid = 4'b0000;
        #1;
        check("drain.in_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("drain", 1'b0, 16'h5678, 2'd1);

        // Reset mid-stream holding 9ABC (pointer at 2)
        in_valid = 4'b0100;
        tick();
        check_out("mid.load", 1'b1, 16'h9ABC, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("mid.async", 1'b0, 16'h0000, 2'd0);
        check("mid.in_ready", 32'(in_ready), 32'h0);
        in_valid = 4'b1111;
        #1;
        rst_n = 1'b1;
        #1;
        check("mid.rel_ready", 32'(in_ready), 32'b0001);
        tick();
        check_out("mid.restart", 1'b1, 16'h1234, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised, registered N-to-1 multiplexer for 16-bit datapath streams.
- Replaces hard-wired sel-driven 4:1 muxes wherever several producers share one consumer, e.g. register-file write-back and memory-bus request merging.
- Selects a source by arbitration: round-robin or fixed priority. Uses valid/ready handshakes on every channel and holds the result in one output register stage.

Parameters:
- WIDTH, 16, data bits per channel.
- NUM_IN, 4, number of input channels; must be >= 2.
- SEL_W, $clog2(NUM_IN), width of the source index. Localparam, derived; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- arb_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins). Sampled every cycle.
- in_valid  input  NUM_IN  per-channel data valid.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_IN  per-channel accept; a transfer happens when in_valid[i] && in_ready[i].
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accept; a transfer happens when out_valid && out_ready.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready is all-zero throughout reset.
- Output register state:
  - EMPTY when out_valid=0; FULL when out_valid=1.
  - can_load = !out_valid || out_ready. This allows back-to-back streaming at one word per cycle.
- Grant logic (combinational, one-hot or zero):
  - Round-robin: grant the first valid channel searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_IN.
  - Fixed priority: grant the lowest-index valid channel; rr_ptr is ignored.
  - No valid inputs: grant=0.
- Handshake:
  - in_ready[i] = grant[i] && can_load.
  - At most one in_ready bit is high per cycle.
  - in_ready depends only on in_valid, arb_mode, rr_ptr, out_valid and out_ready; no combinational path from in_data.
- Load on a clk edge where a grant for channel k exists and can_load=1:
  - out_data <= channel k data; out_sel <= k; out_valid <= 1.
  - Round-robin: rr_ptr <= (k+1) mod NUM_IN, wrapping from NUM_IN-1 to 0.
  - Fixed priority: rr_ptr unchanged.
- Drain: out_valid && out_ready with no grant → out_valid <= 0. out_data and out_sel hold their last values.
- Stall: out_valid && !out_ready → out_data, out_sel and out_valid hold; all in_ready=0.
- Simultaneous drain and load in the same cycle: the new word replaces the old one; out_valid stays 1. No bubble.
- Latency: 1 cycle from input transfer to out_valid.
- Producers must hold in_valid and in_data until accepted. The block drops no data and duplicates no data.
- arb_mode change takes effect on the next grant evaluation. A word already loaded into the output register is unaffected.
- Reset asserted mid-transfer: the held word is discarded and the state returns to reset values immediately (asynchronously). Operation resumes on the first clk edge after rst_n rises.

Test Plan:
- Reset and idle: rst_n=0 with all in_valid=1 → out_valid=0, out_data=16'h0000, in_ready=4'b0000. Release reset, hold out_ready=1 → first out_data=16'h1234 on the next cycle.
- Round-robin fairness: in0..3 = 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, all valid continuously, out_ready=1, arb_mode=0 → out_sel sequence 0,1,2,3,0 on consecutive cycles, with out_data matching each channel.
- Fixed priority: same stimulus with arb_mode=1 → out_sel=0 and out_data=16'h1234 every cycle; in_ready[3:1] never asserted.
- Backpressure: out_ready=0 for 3 cycles while FULL with 16'h5678 → out_data stable and in_ready=0 throughout. Raise out_ready → next word loads with no bubble cycle.
- Sparse and wrap: only in_valid[3]=1 with rr_ptr=3, then only in_valid[0]=1 → out_sel 3 then 0. rr_ptr wraps to 0, then advances to 1.
- Reset mid-stream: assert rst_n=0 while out_valid=1 holding 16'h9ABC → out_valid drops immediately, without waiting for a clk edge. After release, arbitration restarts from channel 0.
